// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Datapath-side responder to the SISC control FSM. It owns the program counter
// (PC) and the instruction register (IR). It fetches instruction words over a
// req/ack instruction-memory port and hands the decoded fields back to ctrl.
//
// Ports
//   clk          system clock, all state updates on posedge
//   rst_f        asynchronous active-low reset
//   pc_rst       synchronous PC/IR/fetch clear from ctrl (aborts a fetch)
//   pc_write     PC load enable
//   pc_sel       0: PC+1, 1: branch target
//   br_sel       1: absolute target (imm), 0: relative target (PC + sext(imm))
//   ir_load      start an instruction fetch at the current PC
//   im_addr      instruction memory address (registered)
//   im_req       instruction memory request (registered)
//   im_rdata     instruction memory read data, valid with im_ack
//   im_ack       memory response; may be combinational from im_req
//   pc_out       current PC
//   ir_out       current instruction word
//   opcode/mm/imm  ir_out[31:28] / ir_out[27:24] / ir_out[15:0]
//   fetch_stall  high while a fetch is outstanding
//   fetch_fault  sticky: a fetch timed out (cleared by pc_rst or rst_f)
//   state_dbg    fetch FSM state, 1 while in WAIT
//
// Handshake: im_req rises together with a registered im_addr and both hold
// steady until the first cycle im_ack is high; that edge completes the
// transfer and drops im_req. im_ack is only sampled while in WAIT. The only
// ways im_req drops without an ack are a timeout or a pc_rst abort.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          pc_rst,
  input  logic          pc_write,
  input  logic          pc_sel,
  input  logic          br_sel,
  input  logic          ir_load,
  output logic [AW-1:0] im_addr,
  output logic          im_req,
  input  logic [DW-1:0] im_rdata,
  input  logic          im_ack,
  output logic [AW-1:0] pc_out,
  output logic [DW-1:0] ir_out,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [15:0]   imm,
  output logic          fetch_stall,
  output logic          fetch_fault,
  output logic          state_dbg
);

  // Timer only has to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_e;

  fetch_state_e  state;
  logic [TW-1:0] timer;

  assign opcode    = ir_out[31:28];
  assign mm        = ir_out[27:24];
  assign imm       = ir_out[15:0];
  assign state_dbg = (state == S_WAIT);

  // ---------------------------------------------------------------------------
  // Program counter. Independent of fetch state, so ctrl may advance the PC
  // on the same edge that launches a fetch (the fetch uses the old value).
  // The size casts zero-extend (absolute) or sign-extend (relative) imm to AW.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc_out <= '0;
    end else if (pc_rst) begin
      pc_out <= '0;
    end else if (pc_write) begin
      if (!pc_sel)
        pc_out <= pc_out + AW'(1);
      else if (br_sel)
        pc_out <= AW'(imm);
      else
        pc_out <= pc_out + AW'($signed(imm));
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM with registered outputs. pc_rst overrides everything, including
  // an ack arriving on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state       <= S_IDLE;
      im_addr     <= '0;
      im_req      <= 1'b0;
      ir_out      <= '0;
      fetch_stall <= 1'b0;
      fetch_fault <= 1'b0;
      timer       <= '0;
    end else if (pc_rst) begin
      state       <= S_IDLE;
      im_req      <= 1'b0;
      ir_out      <= '0;
      fetch_stall <= 1'b0;
      fetch_fault <= 1'b0;
      timer       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ir_load) begin
            im_addr     <= pc_out;
            im_req      <= 1'b1;
            fetch_stall <= 1'b1;
            timer       <= '0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (im_ack) begin
            ir_out      <= im_rdata;
            im_req      <= 1'b0;
            fetch_stall <= 1'b0;
            state       <= S_IDLE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            // Abandon the fetch: present a NOOP and flag the fault.
            ir_out      <= '0;
            fetch_fault <= 1'b1;
            im_req      <= 1'b0;
            fetch_stall <= 1'b0;
            state       <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Drives fetch_unit with directed scenarios followed by randomized traffic.
// A behavioural model (plain integer PC arithmetic, a busy flag and a
// no-ack cycle count) predicts every output each cycle; completed fetches
// also go through an expected-word queue. Inputs change on the negedge,
// outputs are compared on the following negedge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_f;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic          pc_rst, pc_write, pc_sel, br_sel, ir_load;
  logic [AW-1:0] im_addr;
  logic          im_req;
  logic [DW-1:0] im_rdata;
  logic          im_ack;
  logic [AW-1:0] pc_out;
  logic [DW-1:0] ir_out;
  logic [3:0]    opcode, mm;
  logic [15:0]   imm;
  logic          fetch_stall, fetch_fault, state_dbg;

  fetch_unit #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .pc_rst      (pc_rst),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .br_sel      (br_sel),
    .ir_load     (ir_load),
    .im_addr     (im_addr),
    .im_req      (im_req),
    .im_rdata    (im_rdata),
    .im_ack      (im_ack),
    .pc_out      (pc_out),
    .ir_out      (ir_out),
    .opcode      (opcode),
    .mm          (mm),
    .imm         (imm),
    .fetch_stall (fetch_stall),
    .fetch_fault (fetch_fault),
    .state_dbg   (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem[256];

  int          m_pc;
  logic [31:0] m_ir;
  bit          m_busy;
  int          m_addr;
  bit          m_fault;
  int          m_waited;     // no-ack cycles spent in the current fetch
  int          cur_delay;    // no-ack cycles memory inserts before acking
  int          next_delay;   // delay applied to the next fetch started

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc     = 0;
    m_ir     = '0;
    m_busy   = 0;
    m_addr   = 0;
    m_fault  = 0;
    m_waited = 0;
    exp_q.delete();
  endtask

  // One clock edge of the architectural behaviour.
  task automatic model_edge(input bit r, input bit w, input bit s, input bit b,
                            input bit l, input bit ack, input logic [31:0] rd);
    int imm16, simm, old_pc;
    imm16  = int'(m_ir & 32'hFFFF);
    simm   = (imm16 >= 32768) ? imm16 - 65536 : imm16;
    old_pc = m_pc;
    if (r)
      m_pc = 0;
    else if (w) begin
      if (!s)      m_pc = (m_pc + 1) % 65536;
      else if (b)  m_pc = imm16;
      else         m_pc = (m_pc + simm + 65536) % 65536;
    end
    if (r) begin
      m_busy = 0; m_ir = '0; m_fault = 0; m_waited = 0;
    end else if (!m_busy) begin
      if (l) begin
        m_busy = 1; m_addr = old_pc; m_waited = 0; cur_delay = next_delay;
      end
    end else if (ack) begin
      m_ir   = rd;
      m_busy = 0;
      exp_q.push_back(rd);
    end else begin
      m_waited++;
      if (m_waited == TIMEOUT) begin
        m_ir = '0; m_fault = 1; m_busy = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] w;
    check_eq("pc_out",      32'(pc_out),      32'(m_pc));
    check_eq("im_addr",     32'(im_addr),     32'(m_addr));
    check_eq("ir_out",      ir_out,           m_ir);
    check_eq("opcode",      32'(opcode),      (m_ir >> 28) & 32'hF);
    check_eq("mm",          32'(mm),          (m_ir >> 24) & 32'hF);
    check_eq("imm",         32'(imm),         m_ir & 32'hFFFF);
    check_eq("im_req",      32'(im_req),      32'(m_busy));
    check_eq("fetch_stall", 32'(fetch_stall), 32'(m_busy));
    check_eq("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    check_eq("state_dbg",   32'(state_dbg),   32'(m_busy));
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check_eq("ir_sb", ir_out, w);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: called at a negedge, drives one cycle, compares at the next negedge.
  // Memory acks once the current fetch has seen cur_delay no-ack cycles.
  // ---------------------------------------------------------------------------
  task automatic step(input bit r, input bit w, input bit s, input bit b, input bit l);
    bit          ack;
    logic [31:0] rd;
    ack      = m_busy && (m_waited >= cur_delay);
    rd       = ack ? mem[m_addr & 255] : $urandom;
    pc_rst   = r;
    pc_write = w;
    pc_sel   = s;
    br_sel   = b;
    ir_load  = l;
    im_ack   = ack;
    im_rdata = rd;
    @(posedge clk);
    model_edge(r, w, s, b, l, ack, rd);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int stall_cnt;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0]     = 32'h1800_0005;
    mem[1]     = 32'h0000_0010;
    mem[16]    = 32'h2000_FFFC;
    next_delay = 0;
    cur_delay  = 0;

    rst_f = 1'b0;
    pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0; ir_load = 0;
    im_ack = 0; im_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check_eq("rst_pc", 32'(pc_out), 32'h0);
    check_eq("rst_ir", ir_out, 32'h0);
    rst_f = 1'b1;

    // 1: zero-wait fetch with PC increment on the launching edge
    step(1, 0, 0, 0, 0);
    next_delay = 0;
    step(0, 1, 0, 0, 1);
    check_eq("t1_addr", 32'(im_addr), 32'h0);
    step(0, 0, 0, 0, 0);
    check_eq("t1_ir",     ir_out,          32'h1800_0005);
    check_eq("t1_opcode", 32'(opcode),     32'h1);
    check_eq("t1_mm",     32'(mm),         32'h8);
    check_eq("t1_pc",     32'(pc_out),     32'h1);

    // 2: absolute and relative branches (fetch imm 0x0010, jump, fetch imm 0xFFFC)
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    check_eq("t2_abs10", 32'(pc_out), 32'h0010);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check_eq("t2_imm", 32'(imm), 32'hFFFC);
    step(0, 1, 1, 0, 0);
    check_eq("t2_rel", 32'(pc_out), 32'h000C);
    step(0, 1, 1, 1, 0);
    check_eq("t2_abs", 32'(pc_out), 32'hFFFC);

    // 3: PC+1 wraps
    repeat (3) step(0, 1, 0, 0, 0);
    check_eq("t3_ffff", 32'(pc_out), 32'hFFFF);
    step(0, 1, 0, 0, 0);
    check_eq("t3_wrap", 32'(pc_out), 32'h0000);

    // 4: ack arrives in the third WAIT cycle; a second ir_load (with pc_write)
    //    during WAIT is ignored and im_addr holds.
    next_delay = 2;
    stall_cnt  = 0;
    step(0, 0, 0, 0, 1);
    if (fetch_stall) stall_cnt++;
    step(0, 1, 0, 0, 1);
    if (fetch_stall) stall_cnt++;
    check_eq("t4_addr_hold", 32'(im_addr), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      if (fetch_stall) stall_cnt++;
    end
    check_eq("t4_stall_cycles", 32'(stall_cnt), 32'd3);
    check_eq("t4_ir", ir_out, 32'h1800_0005);
    check_eq("t4_pc", 32'(pc_out), 32'h1);

    // 5: timeout after TIMEOUT no-ack cycles, fault sticky until pc_rst
    next_delay = 99;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0, 0);
    check_eq("t5_still_stall", 32'(fetch_stall), 32'h1);
    step(0, 0, 0, 0, 0);
    check_eq("t5_fault", 32'(fetch_fault), 32'h1);
    check_eq("t5_ir",    ir_out,           32'h0);
    check_eq("t5_req",   32'(im_req),      32'h0);
    next_delay = 0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check_eq("t5_sticky", 32'(fetch_fault), 32'h1);
    step(1, 0, 0, 0, 0);
    check_eq("t5_clear", 32'(fetch_fault), 32'h0);

    // 6: pc_rst in WAIT beats a same-edge ack
    step(0, 1, 0, 0, 0);
    next_delay = 0;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    check_eq("t6_req",   32'(im_req),    32'h0);
    check_eq("t6_ir",    ir_out,         32'h0);
    check_eq("t6_pc",    32'(pc_out),    32'h0);
    check_eq("t6_state", 32'(state_dbg), 32'h0);

    // 6b: async reset pulse mid-WAIT, no clock edge in between
    next_delay = 99;
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0; ir_load = 0; im_ack = 0;
    #2 rst_f = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_eq("t6_arst_pc",  32'(pc_out),    32'h0);
    check_eq("t6_arst_req", 32'(im_req),    32'h0);
    check_eq("t6_arst_addr", 32'(im_addr),  32'h0);
    #1 rst_f = 1'b1;
    step(0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      next_delay = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      step($urandom_range(0, 24) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
